avg_unit: RTL and testbench

AVG_UNIT -- requirements
Module: avg_unit

---
 rtl/avg_pkg.sv | 19 +
 rtl/avg_unit_if.sv | 13 +
 rtl/fp16_add.sv | 105 ++++++++++
 rtl/avg_unit.sv | 49 ++++
 tb/tb_avg_unit.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/avg_pkg.sv
// Shared constants and FP16 helpers for the four-element averaging unit.
// The 0.25 scale is a pure exponent decrement, so it lives here as a function.
package avg_pkg;

   localparam int          DATA_WIDTH = 16;
   localparam int          SIZE       = 4;
   localparam logic [15:0] QUARTER    = 16'h3400;
   localparam logic [15:0] FP16_NAN   = 16'h7E00;

   // Multiply by 2^-sh; anything that would land in the subnormal range becomes signed zero.
   function automatic logic [15:0] fp16_scale(input logic [15:0] v, input int sh);
      if (v[14:10] == 5'h1f)
         return v;
      if (int'(v[14:10]) <= sh)
         return {v[15], 15'h0000};
      return {v[15], v[14:10] - 5'(sh), v[9:0]};
   endfunction

endpackage

// File: rtl/avg_unit_if.sv
// Operand/result bundle of the averaging unit: four packed FP16 elements in, one FP16 mean out.
interface avg_unit_if
   import avg_pkg::*;
#(
   parameter int DW = DATA_WIDTH,
   parameter int N  = SIZE
);
   logic [DW*N-1:0] x;
   logic [DW-1:0]   AvgOut;

   modport master (output x, input AvgOut);
   modport slave  (input x, output AvgOut);
endinterface

// File: rtl/fp16_add.sv
// Combinational binary16 adder: round-to-nearest-even, subnormals flushed to zero,
// any NaN or opposite infinities give the canonical quiet NaN.
module fp16_add
   import avg_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] y
);

   logic              sa, sb, sl, ss;
   logic [4:0]        ea, eb, el, es, d;
   logic [9:0]        fa, fb;
   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic              swap, st, up;
   logic [13:0]       ml, ms, ms_sh, nrm;
   logic [14:0]       acc;
   logic [3:0]        lz;
   logic signed [6:0] e;
   logic [11:0]       rnd;

   always_comb begin
      sa = a[15];
      ea = a[14:10];
      fa = a[9:0];
      sb = b[15];
      eb = b[14:10];
      fb = b[9:0];

      a_nan  = (ea == 5'h1f) && (fa != 10'h000);
      b_nan  = (eb == 5'h1f) && (fb != 10'h000);
      a_inf  = (ea == 5'h1f) && (fa == 10'h000);
      b_inf  = (eb == 5'h1f) && (fb == 10'h000);
      a_zero = (ea == 5'h00);
      b_zero = (eb == 5'h00);

      swap = {eb, fb} > {ea, fa};
      sl   = swap ? sb : sa;
      ss   = swap ? sa : sb;
      el   = swap ? eb : ea;
      es   = swap ? ea : eb;
      ml   = {1'b1, (swap ? fb : fa), 3'b000};
      ms   = {1'b1, (swap ? fa : fb), 3'b000};
      d    = el - es;

      // Guard/round bits are carried in the three low bits; everything shifted further is sticky.
      if (d >= 5'd14) begin
         ms_sh = '0;
         st    = 1'b1;
      end else begin
         ms_sh = ms >> d;
         st    = |(ms & ((14'd1 << d) - 14'd1));
      end
      ms_sh[0] = ms_sh[0] | st;

      acc = '0;
      nrm = '0;
      lz  = '0;
      if (sl == ss) begin
         acc = {1'b0, ml} + {1'b0, ms_sh};
         if (acc[14]) begin
            nrm    = acc[14:1];
            nrm[0] = acc[1] | acc[0];
            e      = $signed({2'b00, el}) + 7'sd1;
         end else begin
            nrm = acc[13:0];
            e   = $signed({2'b00, el});
         end
      end else begin
         acc = {1'b0, ml} - {1'b0, ms_sh};
         for (int i = 0; i <= 13; i++)
            if (acc[i])
               lz = 4'(13 - i);
         nrm = acc[13:0] << lz;
         e   = $signed({2'b00, el}) - $signed({3'b000, lz});
      end

      up  = nrm[2] & (nrm[3] | nrm[1] | nrm[0]);
      rnd = {1'b0, nrm[13:3]} + {11'b0, up};
      if (rnd[11])
         e = e + 7'sd1;

      if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
         y = FP16_NAN;
      else if (a_inf)
         y = {sa, 15'h7c00};
      else if (b_inf)
         y = {sb, 15'h7c00};
      else if (a_zero && b_zero)
         y = {sa & sb, 15'h0000};
      else if (a_zero)
         y = b;
      else if (b_zero)
         y = a;
      else if (acc == 15'h0000)
         y = 16'h0000;
      else if (e <= 7'sd0)
         y = 16'h0000;
      else if (e >= 7'sd31)
         y = {sl, 15'h7c00};
      else
         y = {sl, e[4:0], (rnd[11] ? rnd[10:1] : rnd[9:0])};
   end

endmodule

// File: rtl/avg_unit.sv
// Accumulates the four packed FP16 elements one per clock, then registers sum * 0.25.
// The result holds, and accumulation stays frozen, until the next reset.
module avg_unit #(
   parameter int          DATA_WIDTH = avg_pkg::DATA_WIDTH,
   parameter int          SIZE       = avg_pkg::SIZE,
   parameter logic [15:0] QUARTER    = avg_pkg::QUARTER
) (
   input  logic [DATA_WIDTH*SIZE-1:0] x,
   output logic [DATA_WIDTH-1:0]      AvgOut,
   input  logic                       clk,
   input  logic                       reset
);

   // Scaling by a power-of-two constant reduces to subtracting its unbiased exponent.
   localparam int         SCALE_SHIFT = 15 - int'(QUARTER[14:10]);
   localparam logic [2:0] LAST        = 3'd4;

   logic [2:0]            cnt;
   logic [DATA_WIDTH-1:0] sum;
   logic [DATA_WIDTH-1:0] add;
   logic [DATA_WIDTH-1:0] elem;

   always_comb begin
      elem = '0;
      for (int i = 0; i < SIZE; i++)
         if (cnt == 3'(i))
            elem = x[DATA_WIDTH*(SIZE-i)-1 -: DATA_WIDTH];
   end

   fp16_add u_add (
      .a (sum),
      .b (elem),
      .y (add)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         sum    <= '0;
         AvgOut <= '0;
      end else if (cnt < LAST) begin
         sum <= add;
         cnt <= cnt + 3'd1;
      end else begin
         AvgOut <= avg_pkg::fp16_scale(sum, SCALE_SHIFT);
      end
   end

endmodule

// File: tb/tb_avg_unit.sv
// Bench for avg_unit: directed vector table, hand sequences for reset/latency/hold,
// and randomized runs against a real-arithmetic FP16 reference model.
module tb_avg_unit;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   avg_unit_if bus ();

   avg_unit dut (
      .x      (bus.x),
      .AvgOut (bus.AvgOut),
      .clk    (clk),
      .reset  (reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no summary, expected completion");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [63:0] x;
      logic [15:0] sum;
      logic [15:0] avg;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model (real arithmetic) ----------------
   function automatic real pow2(input int k);
      real p;
      p = 1.0;
      if (k >= 0)
         for (int i = 0; i < k; i++) p = p * 2.0;
      else
         for (int i = 0; i < -k; i++) p = p / 2.0;
      return p;
   endfunction

   function automatic real to_real(input logic [15:0] v);
      real mag;
      if (v[14:10] == 5'h00)
         return 0.0;
      mag = (1024.0 + real'(v[9:0])) * pow2(int'(v[14:10]) - 25);
      return v[15] ? -mag : mag;
   endfunction

   // Nearest-even conversion of a nonzero finite real; results below the normal range become +0.
   function automatic logic [15:0] to_fp16(input real r);
      logic s;
      real  a, m, fl, fr;
      int   e, mi;
      s = (r < 0.0);
      a = s ? -r : r;
      e = 0;
      while (a >= pow2(e + 1)) e++;
      while (a < pow2(e)) e--;
      if (e < -14)
         return 16'h0000;
      m  = a / pow2(e - 10);
      fl = $floor(m);
      fr = m - fl;
      mi = $rtoi(fl);
      if (fr > 0.5 || (fr == 0.5 && (mi % 2) == 1))
         mi++;
      if (mi == 2048) begin
         mi = 1024;
         e++;
      end
      if (e > 15)
         return {s, 15'h7c00};
      return {s, 5'(e + 15), 10'(mi - 1024)};
   endfunction

   function automatic logic [15:0] ref_add(input logic [15:0] a_in, input logic [15:0] b_in);
      logic [15:0] a, b;
      logic        a_nan, b_nan, a_inf, b_inf;
      real         r;
      a = (a_in[14:10] == 5'h00) ? {a_in[15], 15'h0000} : a_in;
      b = (b_in[14:10] == 5'h00) ? {b_in[15], 15'h0000} : b_in;
      a_nan = (a[14:10] == 5'h1f) && (a[9:0] != 0);
      b_nan = (b[14:10] == 5'h1f) && (b[9:0] != 0);
      a_inf = (a[14:0] == 15'h7c00);
      b_inf = (b[14:0] == 15'h7c00);
      if (a_nan || b_nan || (a_inf && b_inf && a[15] != b[15]))
         return 16'h7E00;
      if (a_inf) return a;
      if (b_inf) return b;
      if (a[14:0] == 0 && b[14:0] == 0)
         return {a[15] & b[15], 15'h0000};
      r = to_real(a) + to_real(b);
      if (r == 0.0)
         return 16'h0000;
      return to_fp16(r);
   endfunction

   function automatic logic [15:0] ref_quarter(input logic [15:0] v);
      real r;
      if (v[14:10] == 5'h1f) return v;
      if (v[14:10] == 5'h00) return {v[15], 15'h0000};
      r = to_real(v) * 0.25;
      if ((r < 0.0 ? -r : r) < pow2(-14))
         return {v[15], 15'h0000};
      return to_fp16(r);
   endfunction

   function automatic logic [15:0] rnd_elem();
      logic [15:0] v;
      v = 16'($urandom);
      case ($urandom_range(0, 31))
         0:       v = {v[15], 15'h7c00};
         1:       v = {v[15], 5'h1f, v[9:0] | 10'h001};
         2:       v = {v[15], 5'h00, v[9:0]};
         3:       v = {v[15], 5'h1e, v[9:0]};
         4:       v = {v[15], 5'($urandom_range(1, 4)), v[9:0]};
         default: v = {v[15], 5'($urandom_range(12, 18)), v[9:0]};
      endcase
      return v;
   endfunction

   task automatic start_run(input logic [63:0] xv);
      @(negedge clk);
      reset = 1'b0;
      bus.x = xv;
      @(negedge clk);
      reset = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] el_q[$];
      logic [15:0] m_sum;
      logic [63:0] xr;
      logic [15:0] s_exp[4];

      n_cmp = 0;
      n_bad = 0;
      reset = 1'b0;
      bus.x = '0;

      #2;
      check("reset sum", dut.sum, 16'h0000);
      check("reset cnt", {13'b0, dut.cnt}, 16'h0000);
      check("reset avg", bus.AvgOut, 16'h0000);

      // 1,2,3,4: per-edge sums, latency, hold with x changing underneath
      s_exp = '{16'h3C00, 16'h4200, 16'h4600, 16'h4900};
      start_run(64'h3C00_4000_4200_4400);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         check($sformatf("seq1 sum edge%0d", k + 1), dut.sum, s_exp[k]);
      end
      check("seq1 avg before edge5", bus.AvgOut, 16'h0000);
      @(posedge clk); #1;
      check("seq1 avg edge5", bus.AvgOut, 16'h4100);
      @(negedge clk);
      bus.x = 64'h7BFF_7BFF_7BFF_7BFF;
      repeat (22) @(posedge clk);
      #1;
      check("seq1 avg hold", bus.AvgOut, 16'h4100);
      check("seq1 sum frozen", dut.sum, 16'h4900);
      check("seq1 cnt sat", {13'b0, dut.cnt}, 16'h0004);

      // Directed table
      vecs.push_back('{x: 64'h4000_4200_4400_4500, sum: 16'h4B00, avg: 16'h4300});
      vecs.push_back('{x: 64'h3C00_BC00_3C00_BC00, sum: 16'h0000, avg: 16'h0000});
      vecs.push_back('{x: 64'h7C00_3C00_4000_4200, sum: 16'h7C00, avg: 16'h7C00});
      vecs.push_back('{x: 64'h7BFF_7BFF_7BFF_7BFF, sum: 16'h7C00, avg: 16'h7C00});
      vecs.push_back('{x: 64'h0C00_0C00_0C00_0C00, sum: 16'h1400, avg: 16'h0C00});
      vecs.push_back('{x: 64'h7C00_FC00_3C00_3C00, sum: 16'h7E00, avg: 16'h7E00});
      vecs.push_back('{x: 64'h3C00_7E55_3C00_3C00, sum: 16'h7E00, avg: 16'h7E00});
      vecs.push_back('{x: 64'h0400_0000_0000_0000, sum: 16'h0400, avg: 16'h0000});
      vecs.push_back('{x: 64'h8400_0000_0000_0000, sum: 16'h8400, avg: 16'h8000});
      vecs.push_back('{x: 64'h0001_0001_0001_0001, sum: 16'h0000, avg: 16'h0000});
      vecs.push_back('{x: 64'h3C00_1000_1000_0000, sum: 16'h3C00, avg: 16'h3400});
      vecs.push_back('{x: 64'h3C00_1400_0000_0000, sum: 16'h3C01, avg: 16'h3401});
      vecs.push_back('{x: 64'hBC00_C000_C200_C400, sum: 16'hC900, avg: 16'hC100});
      vecs.push_back('{x: 64'h0800_0800_0800_0800, sum: 16'h1000, avg: 16'h0800});
      for (int i = 0; i < vecs.size(); i++) begin
         start_run(vecs[i].x);
         repeat (5) @(posedge clk);
         #1;
         check($sformatf("vec%0d sum", i), dut.sum, vecs[i].sum);
         check($sformatf("vec%0d avg", i), bus.AvgOut, vecs[i].avg);
      end

      // Reset in the middle of a run, then a clean run
      start_run(64'h3C00_4000_4200_4400);
      repeat (2) @(posedge clk);
      #1;
      check("abort sum before", dut.sum, 16'h4200);
      #2;
      reset = 1'b0;
      #1;
      check("abort sum", dut.sum, 16'h0000);
      check("abort cnt", {13'b0, dut.cnt}, 16'h0000);
      check("abort avg", bus.AvgOut, 16'h0000);
      start_run(64'h4000_4200_4400_4500);
      repeat (5) @(posedge clk);
      #1;
      check("after abort avg", bus.AvgOut, 16'h4300);

      // Randomized runs; x changes every cycle so only element[cnt] of the live value counts
      for (int r = 0; r < 60; r++) begin
         el_q.delete();
         @(negedge clk);
         reset = 1'b0;
         @(negedge clk);
         reset = 1'b1;
         for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++)
               xr[63 - 16*j -: 16] = rnd_elem();
            bus.x = xr;
            if (k < 4)
               el_q.push_back(xr[63 - 16*k -: 16]);
            @(negedge clk);
         end
         m_sum = 16'h0000;
         foreach (el_q[k])
            m_sum = ref_add(m_sum, el_q[k]);
         check($sformatf("rand%0d sum", r), dut.sum, m_sum);
         check($sformatf("rand%0d avg", r), bus.AvgOut, ref_quarter(m_sum));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
